// File: rtl/lpc_sniffer_pkg.sv
// Shared definitions for the LPC sniffer: scheduler FSM states, framing bytes
// and default geometry of the capture buffer.
package lpc_sniffer_pkg;

  localparam int DEFAULT_AW            = 8;
  localparam int DEFAULT_SLOT_BITS     = 5;
  localparam int DEFAULT_PAYLOAD_BYTES = 6;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_OVF_BYTE  = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OVF,
    ST_HDR,
    ST_RD,
    ST_RDW,
    ST_SEND,
    ST_ACK,
    ST_NEXT
  } sched_state_t;

endpackage

// File: rtl/lpc_uart_scheduler_sync2.sv
// Two-flop synchroniser for single-bit level signals crossing into ext_clock.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/lpc_uart_scheduler.sv
// Drains captured LPC records slot by slot to uart_tx: sync byte, payload bytes,
// slot release, and an in-band marker byte once per overflow episode.
module lpc_uart_scheduler
  import lpc_sniffer_pkg::*;
#(
  parameter int         AW            = DEFAULT_AW,
  parameter int         SLOT_BITS     = DEFAULT_SLOT_BITS,
  parameter int         PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter logic [7:0] OVF_BYTE      = DEFAULT_OVF_BYTE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 empty,
  input  logic                 overflow,
  input  logic [SLOT_BITS-1:0] read_slot,
  output logic [AW-1:0]        read_addr,
  output logic                 read_latch,
  input  logic [7:0]           read_data,
  output logic                 read_done,
  input  logic                 uart_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_latch,
  output logic                 ovf_flag
);

  localparam int            IB       = AW - SLOT_BITS;
  localparam logic [IB-1:0] LAST_IDX = IB'(PAYLOAD_BYTES - 1);

  sched_state_t         state;
  sched_state_t         ret_state;
  logic [SLOT_BITS-1:0] slot_q;
  logic [IB-1:0]        idx;
  logic                 ovf_pend;
  logic                 overflow_s_d;
  logic                 ack_low;
  logic [1:0]           hold;
  logic                 empty_s;
  logic                 overflow_s;
  logic                 ovf_rise;

  sync2 u_sync_empty (
    .clock (clock),
    .reset (reset),
    .d     (empty),
    .q     (empty_s)
  );

  sync2 u_sync_overflow (
    .clock (clock),
    .reset (reset),
    .d     (overflow),
    .q     (overflow_s)
  );

  assign ovf_rise = overflow_s & ~overflow_s_d;
  assign ovf_flag = ovf_pend;

  // hold keeps IDLE quiet until empty_s has caught up with a just-released slot
  // (and with the ringbuffer state after reset), so a stale !empty_s never re-sends it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ret_state    <= ST_IDLE;
      slot_q       <= '0;
      idx          <= '0;
      ovf_pend     <= 1'b0;
      overflow_s_d <= 1'b0;
      ack_low      <= 1'b0;
      hold         <= 2'd3;
      read_addr    <= '0;
      read_latch   <= 1'b0;
      read_done    <= 1'b0;
      uart_data    <= '0;
      uart_latch   <= 1'b0;
    end else begin
      overflow_s_d <= overflow_s;
      read_latch   <= 1'b0;
      read_done    <= 1'b0;
      uart_latch   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold != 2'd0) begin
            hold <= hold - 2'd1;
          end else if (ovf_pend || ovf_rise) begin
            state <= ST_OVF;
          end else if (!empty_s) begin
            slot_q <= read_slot;
            idx    <= '0;
            state  <= ST_HDR;
          end
        end
        ST_OVF: begin
          uart_data <= OVF_BYTE;
          ret_state <= ST_IDLE;
          state     <= ST_SEND;
        end
        ST_HDR: begin
          uart_data <= SYNC_BYTE;
          ret_state <= ST_RD;
          state     <= ST_SEND;
        end
        ST_RD: begin
          read_addr  <= {slot_q, idx};
          read_latch <= 1'b1;
          state      <= ST_RDW;
        end
        // read_data is only valid in the cycle after the read_latch pulse
        ST_RDW: begin
          if (!read_latch) begin
            uart_data <= read_data;
            ret_state <= ST_NEXT;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (uart_ready) begin
            uart_latch <= 1'b1;
            ack_low    <= 1'b0;
            state      <= ST_ACK;
            if (ret_state == ST_IDLE) begin
              ovf_pend <= 1'b0;
            end
          end
        end
        ST_ACK: begin
          if (!uart_ready) begin
            ack_low <= 1'b1;
          end else if (ack_low) begin
            state <= ret_state;
          end
        end
        ST_NEXT: begin
          if (idx == LAST_IDX) begin
            read_done <= 1'b1;
            hold      <= 2'd3;
            state     <= ST_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A fresh overflow edge outranks the clear from a marker being latched.
      if (ovf_rise) begin
        ovf_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lpc_uart_scheduler.sv
// Bench for lpc_uart_scheduler: ringbuffer, buffer and uart_tx models plus a
// byte-stream reference model checked on every cycle.
module tb_lpc_uart_scheduler;

  localparam int PB = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       empty = 1'b1;
  logic       overflow = 1'b0;
  logic [4:0] read_slot = 5'd0;
  logic [7:0] read_addr;
  logic       read_latch;
  logic [7:0] read_data = 8'd0;
  logic       read_done;
  logic       uart_ready = 1'b1;
  logic [7:0] uart_data;
  logic       uart_latch;
  logic       ovf_flag;

  always #5 clock = ~clock;

  lpc_uart_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .empty      (empty),
    .overflow   (overflow),
    .read_slot  (read_slot),
    .read_addr  (read_addr),
    .read_latch (read_latch),
    .read_data  (read_data),
    .read_done  (read_done),
    .uart_ready (uart_ready),
    .uart_data  (uart_data),
    .uart_latch (uart_latch),
    .ovf_flag   (ovf_flag)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] mem [256];
  logic [4:0] q [$];
  int         low_cnt = 0;
  bit         stall = 1'b0;

  int         cnt = 0;
  bit         m_flag = 1'b0;
  logic [3:0] ov_h = 4'd0;
  bit         busy = 1'b0;
  bit         seen_low = 1'b0;
  logic [7:0] busy_data = 8'd0;
  logic [4:0] cur_slot = 5'd0;
  int         latch_total = 0;
  int         done_total = 0;
  logic [7:0] uart_log [$];
  logic [7:0] addr_log [$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock of environment: ringbuffer pop, uart_tx ready pacing, buffer read.
  task automatic apply_stimulus();
    @(negedge clock);
    if (reset && read_done && q.size() > 0) void'(q.pop_front());
    empty = (q.size() == 0);
    read_slot = (q.size() > 0) ? q[0] : 5'd0;
    if (uart_latch) low_cnt = 10;
    if (stall) uart_ready = 1'b0;
    else if (low_cnt > 0) begin
      uart_ready = 1'b0;
      low_cnt--;
    end else uart_ready = 1'b1;
    if (read_latch) read_data = mem[read_addr];
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || cnt != 0 || m_flag || busy) && n < 6000) begin
      apply_stimulus();
      n++;
    end
    check_output("idle_timeout", 32'(n < 6000), 1);
    repeat (20) apply_stimulus();
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (cnt != target && n < 3000) begin
      apply_stimulus();
      n++;
    end
    check_output("wait_cnt_timeout", 32'(n < 3000), 1);
  endtask

  // Reference model: the byte stream is [5A] A5 p0..p5 per record, read_done
  // only after the last payload byte, overflow seen two edges after it rises.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check_output("reset_outputs",
                   {12'd0, read_addr, read_latch, read_done, uart_data, uart_latch, ovf_flag}, 0);
      cnt = 0;
      m_flag = 1'b0;
      ov_h = 4'd0;
      busy = 1'b0;
    end else begin
      ov_h = {ov_h[2:0], overflow};
      if (busy) begin
        check_output("data_stable", uart_data, busy_data);
        if (!uart_ready) seen_low = 1'b1;
        else if (seen_low) busy = 1'b0;
      end
      if (uart_latch) begin
        check_output("double_latch", busy, 0);
        busy = 1'b1;
        seen_low = 1'b0;
        busy_data = uart_data;
        latch_total++;
        uart_log.push_back(uart_data);
        if (cnt == 0) begin
          if (m_flag) begin
            check_output("ovf_byte", uart_data, 8'h5A);
            m_flag = 1'b0;
          end else if (q.size() == 0) begin
            check_output("spurious_latch", uart_latch, 0);
          end else begin
            check_output("sync_byte", uart_data, 8'hA5);
            cur_slot = q[0];
            cnt = 1;
          end
        end else if (cnt <= PB) begin
          check_output("payload", uart_data, mem[{cur_slot, 3'(cnt - 1)}]);
          cnt++;
        end else begin
          check_output("latch_before_done", uart_latch, 0);
        end
      end
      if (read_latch) begin
        addr_log.push_back(read_addr);
        check_output("read_addr", read_addr, {cur_slot, 3'(cnt - 1)});
      end
      if (read_done) begin
        check_output("done_position", cnt, PB + 1);
        done_total++;
        cnt = 0;
      end
      if (ov_h[2] && !ov_h[3]) m_flag = 1'b1;
      check_output("ovf_flag", ovf_flag, m_flag);
    end
  end

  initial begin
    int d0;
    int lt;
    int n;
    int ovf_left;
    logic [7:0] exp1 [7];
    exp1 = '{8'hA5, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) apply_stimulus();
    check_output("rst_read_addr", read_addr, 0);
    check_output("rst_uart_data", uart_data, 0);
    reset = 1'b1;
    repeat (8) apply_stimulus();
    check_output("idle_no_latch", latch_total, 0);

    $display("[TB] single record, slot 5");
    for (int i = 0; i < PB; i++) mem[8'h28 + i] = 8'h11 + 8'(i);
    uart_log.delete(); addr_log.delete(); d0 = done_total;
    q.push_back(5'd5);
    wait_idle();
    check_output("t1_len", uart_log.size(), 7);
    for (int i = 0; i < 7; i++) check_output("t1_byte", uart_log[i], exp1[i]);
    for (int i = 0; i < PB; i++) check_output("t1_addr", addr_log[i], 8'h28 + i);
    check_output("t1_done", done_total - d0, 1);

    $display("[TB] three slots with wrap");
    uart_log.delete(); addr_log.delete(); d0 = done_total;
    q.push_back(5'd30); q.push_back(5'd31); q.push_back(5'd0);
    wait_idle();
    check_output("t2_done", done_total - d0, 3);
    check_output("t2_addr_len", addr_log.size(), 18);
    check_output("t2_slot_a", addr_log[0] >> 3, 30);
    check_output("t2_slot_b", addr_log[6] >> 3, 31);
    check_output("t2_slot_c", addr_log[12] >> 3, 0);
    check_output("t2_hdr", uart_log[14], 8'hA5);

    $display("[TB] overflow mid-record");
    uart_log.delete(); addr_log.delete();
    q.push_back(5'd7); q.push_back(5'd9);
    wait_cnt(3);
    overflow = 1'b1;
    apply_stimulus(); check_output("t3_flag_e1", ovf_flag, 0);
    apply_stimulus(); check_output("t3_flag_e2", ovf_flag, 0);
    apply_stimulus(); check_output("t3_flag_e3", ovf_flag, 1);
    overflow = 1'b0;
    wait_idle();
    check_output("t3_len", uart_log.size(), 15);
    check_output("t3_marker", uart_log[7], 8'h5A);
    check_output("t3_next_hdr", uart_log[8], 8'hA5);
    check_output("t3_flag_end", ovf_flag, 0);

    $display("[TB] overflow with data pending at idle");
    uart_log.delete(); addr_log.delete();
    q.push_back(5'd12);
    overflow = 1'b1;
    repeat (3) apply_stimulus();
    overflow = 1'b0;
    wait_idle();
    check_output("t4_first", uart_log[0], 8'h5A);
    check_output("t4_second", uart_log[1], 8'hA5);
    check_output("t4_len", uart_log.size(), 8);

    $display("[TB] two overflow pulses before service");
    for (int i = 0; i < PB; i++) begin
      mem[24 + i] = 8'h30 + 8'(i);
      mem[32 + i] = 8'h40 + 8'(i);
    end
    uart_log.delete(); addr_log.delete();
    q.push_back(5'd3); q.push_back(5'd4);
    wait_cnt(2);
    repeat (2) begin
      overflow = 1'b1;
      repeat (3) apply_stimulus();
      overflow = 1'b0;
      repeat (3) apply_stimulus();
    end
    wait_idle();
    check_output("t4b_len", uart_log.size(), 15);
    check_output("t4b_marker", uart_log[7], 8'h5A);
    check_output("t4b_hdr", uart_log[8], 8'hA5);

    $display("[TB] uart_ready stuck low");
    uart_log.delete(); addr_log.delete(); d0 = done_total;
    q.push_back(5'd20);
    wait_cnt(1);
    stall = 1'b1;
    lt = latch_total;
    repeat (1000) apply_stimulus();
    check_output("t5_no_latch", latch_total, lt);
    check_output("t5_data_held", uart_data, 8'hA5);
    check_output("t5_cnt", cnt, 1);
    stall = 1'b0;
    wait_idle();
    check_output("t5_len", uart_log.size(), 7);
    check_output("t5_done", done_total - d0, 1);

    $display("[TB] reset in the middle of a record");
    d0 = done_total;
    q.push_back(5'd21); q.push_back(5'd22);
    n = 0;
    while (!(read_latch && read_addr == 8'hAA) && n < 3000) begin
      apply_stimulus();
      n++;
    end
    check_output("t6_reach_rdw", 32'(n < 3000), 1);
    reset = 1'b0;
    #1;
    check_output("t6_read_addr", read_addr, 0);
    check_output("t6_read_latch", read_latch, 0);
    check_output("t6_uart_data", uart_data, 0);
    check_output("t6_uart_latch", uart_latch, 0);
    check_output("t6_read_done", read_done, 0);
    check_output("t6_ovf_flag", ovf_flag, 0);
    repeat (3) apply_stimulus();
    reset = 1'b1;
    uart_log.delete(); addr_log.delete();
    wait_idle();
    check_output("t6_done", done_total - d0, 2);
    check_output("t6_resend_hdr", uart_log[0], 8'hA5);
    check_output("t6_resend_addr", addr_log[0], 8'hA8);
    check_output("t6_len", uart_log.size(), 14);

    $display("[TB] randomized traffic");
    d0 = done_total;
    ovf_left = 0;
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 39) == 0 && q.size() < 4) q.push_back(5'($urandom));
      if (ovf_left > 0) begin
        ovf_left--;
        if (ovf_left == 0) overflow = 1'b0;
      end else if (!overflow && cnt >= 1 && cnt <= 4 && $urandom_range(0, 59) == 0) begin
        overflow = 1'b1;
        ovf_left = 3;
      end
      apply_stimulus();
    end
    overflow = 1'b0;
    wait_idle();
    check_output("rand_progress", 32'(done_total > d0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
